alu_operand_stage: RTL and testbench
====================================

# alu_operand_stage

Registered ALU operand-preparation stage for the MIPS datapath. It sits between register-file read and the ALU. It extends the instruction immediate in a selectable mode and selects ALU operand B from the register value or the extended immediate. It presents the result through a valid/ready pipeline register with a one-entry skid buffer, so downstream stalls never drop operands.

## Interface
- `DATA_W`, 32: datapath width in bits.
- `IMM_W`, 16: immediate width in bits; constraint 1 ≤ IMM_W ≤ DATA_W.
- `clk`  in  1: single clock; all state updates on rising edge.
- `reset`  in  1: synchronous, active-high; sampled on rising edge of `clk`.
- `in_valid`  in  1: upstream offers an operand set this cycle.
- `in_ready`  out  1: stage accepts the offer this cycle.
- `in_rs`  in  DATA_W: register value for operand A.
- `in_rt`  in  DATA_W: register value for operand B candidate.
- `in_imm`  in  IMM_W: raw immediate field.
- `in_ext_mode`  in  2: 00 sign-extend, 01 zero-extend, 10 upper (imm placed in MSBs, low bits zero), 11 illegal.
- `in_src_sel`  in  1: 0 → B = `in_rt`, 1 → B = extended immediate.
- `out_valid`  out  1: output holds a valid operand set.
- `out_ready`  in  1: downstream consumes this cycle.
- `out_a`  out  DATA_W: operand A (= captured `in_rs`).
- `out_b`  out  DATA_W: selected operand B.
- `out_imm_ext`  out  DATA_W: extended immediate, always forwarded for branch/offset use.
- `out_err`  out  1: captured set used illegal `in_ext_mode`.

## Operation
- Accept on `in_valid && in_ready`; consume on `out_valid && out_ready`.
- Extension, combinational, before capture:
  - sign: replicate `in_imm[IMM_W-1]` into bits DATA_W-1:IMM_W.
  - zero: upper bits zero.
  - upper: `in_imm << (DATA_W-IMM_W)`; when IMM_W == DATA_W, result equals `in_imm`.
  - illegal: result is zero-extend and `err` = 1 for that entry.
- B select is applied before capture; `err` travels with its entry.
- Storage is a main output register and one skid register. Each holds a, b, imm_ext, err and a valid bit.
- States, encoded by the valid bits:
  - EMPTY: main empty, skid empty.
  - ONE: main full, skid empty.
  - FULL: both full.
- `in_ready` = skid register empty. It is a registered value, not combinational from `out_ready`.
- Transitions:
  - EMPTY + accept → ONE.
  - ONE + accept, no consume → FULL (new entry into skid).
  - ONE + accept + consume → ONE (new entry into main).
  - ONE + consume only → EMPTY.
  - FULL + consume → ONE (skid moves to main). No accept is possible in FULL.
- Strict FIFO order; no entry is lost or duplicated.
- While `out_valid` = 1 and `out_ready` = 0, all `out_*` values hold stable.
- Reset: state EMPTY, `out_valid` = 0, `in_ready` = 1, `out_a`/`out_b`/`out_imm_ext` = 0, `out_err` = 0. Reset mid-transfer discards both entries. An `in_valid` in the reset cycle is not accepted.

## Timing
- Latency: accept in cycle N → `out_valid` and data visible in cycle N+1.
- Throughput is one set per cycle while `out_ready` stays high.
- Downstream stall: up to 2 sets are buffered. `in_ready` falls in the cycle after the second accept without a consume, and rises in the cycle after the next consume.
- Accept and consume in the same cycle in ONE are legal and keep full throughput.
- Only `out_*` and `in_ready` are driven from flops. No combinational path from `out_ready` to `in_ready`.

## Structure
- Shared package `mips_pkg`:
  - ext-mode constants `EXT_SIGN`, `EXT_ZERO`, `EXT_UPPER`, `EXT_ILLEGAL`.
  - default widths `DATA_W` = 32, `IMM_W` = 16.
- Sub-module `imm_extender`: combinational, parameterised by DATA_W/IMM_W. Inputs are imm and mode; outputs are ext and err. It is reused by the branch-target path.
- Top of this block holds the B-select mux, the two-entry register and the state/ready logic.

## Test plan
- Extension modes with imm 16'hf145, `in_src_sel` = 1:
  - sign → `out_b` = 32'hfffff145.
  - zero → 32'h0000f145.
  - upper → 32'hf1450000.
  - mode 11 → 32'h0000f145 with `out_err` = 1.
  - In all cases `out_valid` rises one cycle after accept.
- Register select: `in_rt` = 32'h3f573921, `in_src_sel` = 0 → `out_b` = 32'h3f573921, `out_imm_ext` still reflects the immediate, `out_a` = `in_rs`.
- Backpressure:
  - Stimulus: hold `out_ready` = 0 and offer sets tagged via `in_rs` = 1, 2, 3 on consecutive cycles.
  - `in_ready` drops after set 2 is accepted, and set 3 waits.
  - After `out_ready` rises, outputs arrive in order 1, 2, 3 with no gaps beyond the stall.
- Streaming: `in_valid` and `out_ready` held at 1 for 8 cycles with incrementing `in_rs` → 8 outputs on consecutive cycles, `in_ready` constantly 1.
- Reset mid-operation: assert `reset` while in FULL → next cycle `out_valid` = 0, `in_ready` = 1, outputs 0. The first post-reset accept appears one cycle later.
- Width parameters:
  - DATA_W = IMM_W = 16, imm 16'h8001: sign/zero/upper → 16'h8001.
  - DATA_W = 64: sign of 16'h8000 → 64'hffffffffffff8000.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: default widths and immediate-extension modes.
package mips_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned IMM_W  = 16;

    localparam logic [1:0] EXT_SIGN    = 2'b00;
    localparam logic [1:0] EXT_ZERO    = 2'b01;
    localparam logic [1:0] EXT_UPPER   = 2'b10;
    localparam logic [1:0] EXT_ILLEGAL = 2'b11;

endpackage

// File: rtl/imm_extender.sv
// Combinational immediate extender (sign / zero / upper); shared with the branch-target path.
module imm_extender #(
    parameter int unsigned DATA_W = mips_pkg::DATA_W,
    parameter int unsigned IMM_W  = mips_pkg::IMM_W
) (
    input  logic [IMM_W-1:0]  i_imm,
    input  logic [1:0]        i_mode,
    output logic [DATA_W-1:0] o_ext_c,
    output logic              o_err_c
);
    import mips_pkg::*;

    logic [DATA_W-1:0] w_sign;
    logic [DATA_W-1:0] w_zero;
    logic [DATA_W-1:0] w_upper;

    // No padding exists when the immediate already spans the datapath.
    generate
        if (IMM_W == DATA_W) begin : g_full
            assign w_sign  = i_imm;
            assign w_zero  = i_imm;
            assign w_upper = i_imm;
        end else begin : g_pad
            localparam int unsigned PAD_W = DATA_W - IMM_W;
            assign w_sign  = {{PAD_W{i_imm[IMM_W-1]}}, i_imm};
            assign w_zero  = {{PAD_W{1'b0}}, i_imm};
            assign w_upper = {i_imm, {PAD_W{1'b0}}};
        end
    endgenerate

    always_comb begin
        o_ext_c = w_zero;
        o_err_c = 1'b0;
        case (i_mode)
            EXT_SIGN:  o_ext_c = w_sign;
            EXT_ZERO:  o_ext_c = w_zero;
            EXT_UPPER: o_ext_c = w_upper;
            default:   o_err_c = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_operand_stage.sv
// ALU operand-preparation stage: immediate extension, B-operand select and a
// valid/ready output register backed by a one-entry skid buffer.
module alu_operand_stage #(
    parameter int unsigned DATA_W = mips_pkg::DATA_W,
    parameter int unsigned IMM_W  = mips_pkg::IMM_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_rs,
    input  logic [DATA_W-1:0] in_rt,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic [1:0]        in_ext_mode,
    input  logic              in_src_sel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [DATA_W-1:0] out_imm_ext,
    output logic              out_err
);
    import mips_pkg::*;

    // State is {skid_valid, main_valid}; 2'b10 cannot occur.
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b01;
    localparam logic [1:0] ST_FULL  = 2'b11;

    logic [1:0]        r_state;
    logic              r_in_ready;
    logic [DATA_W-1:0] r_main_a, r_main_b, r_main_imm;
    logic              r_main_err;
    logic [DATA_W-1:0] r_skid_a, r_skid_b, r_skid_imm;
    logic              r_skid_err;

    logic [DATA_W-1:0] w_ext;
    logic              w_ext_err;
    logic [DATA_W-1:0] w_new_b;
    logic              w_accept;
    logic              w_consume;
    logic [1:0]        w_nxt_state;
    logic              w_load_main_new;
    logic              w_load_main_skid;
    logic              w_load_skid;

    imm_extender #(
        .DATA_W (DATA_W),
        .IMM_W  (IMM_W)
    ) u_imm_extender (
        .i_imm   (in_imm),
        .i_mode  (in_ext_mode),
        .o_ext_c (w_ext),
        .o_err_c (w_ext_err)
    );

    assign w_new_b   = in_src_sel ? w_ext : in_rt;
    assign w_accept  = in_valid && r_in_ready;
    assign w_consume = r_state[0] && out_ready;

    always_comb begin
        w_nxt_state      = r_state;
        w_load_main_new  = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_nxt_state     = ST_ONE;
                    w_load_main_new = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_accept && w_consume) begin
                    w_load_main_new = 1'b1;
                end else if (w_accept) begin
                    w_nxt_state = ST_FULL;
                    w_load_skid = 1'b1;
                end else if (w_consume) begin
                    w_nxt_state = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_consume) begin
                    w_nxt_state      = ST_ONE;
                    w_load_main_skid = 1'b1;
                end
            end
            default: w_nxt_state = ST_EMPTY;
        endcase
    end

    // in_ready is registered from the next state, so out_ready never reaches it combinationally.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
            r_main_a   <= '0;
            r_main_b   <= '0;
            r_main_imm <= '0;
            r_main_err <= 1'b0;
            r_skid_a   <= '0;
            r_skid_b   <= '0;
            r_skid_imm <= '0;
            r_skid_err <= 1'b0;
        end else begin
            r_state    <= w_nxt_state;
            r_in_ready <= (w_nxt_state != ST_FULL);
            if (w_load_main_new) begin
                r_main_a   <= in_rs;
                r_main_b   <= w_new_b;
                r_main_imm <= w_ext;
                r_main_err <= w_ext_err;
            end else if (w_load_main_skid) begin
                r_main_a   <= r_skid_a;
                r_main_b   <= r_skid_b;
                r_main_imm <= r_skid_imm;
                r_main_err <= r_skid_err;
            end
            if (w_load_skid) begin
                r_skid_a   <= in_rs;
                r_skid_b   <= w_new_b;
                r_skid_imm <= w_ext;
                r_skid_err <= w_ext_err;
            end
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_state[0];
    assign out_a       = r_main_a;
    assign out_b       = r_main_b;
    assign out_imm_ext = r_main_imm;
    assign out_err     = r_main_err;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage plus width checks on imm_extender.
module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_rs, in_rt;
    logic [15:0] in_imm;
    logic [1:0]  in_ext_mode;
    logic        in_src_sel;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_a, out_b, out_imm_ext;
    logic        out_err;

    logic [15:0] e16_imm;
    logic [1:0]  e16_mode;
    logic [15:0] e16_ext;
    logic        e16_err;
    logic [15:0] e64_imm;
    logic [1:0]  e64_mode;
    logic [63:0] e64_ext;
    logic        e64_err;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   n_pop  = 0;

    always #5 clk = ~clk;

    alu_operand_stage #(.DATA_W(32), .IMM_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_rs       (in_rs),
        .in_rt       (in_rt),
        .in_imm      (in_imm),
        .in_ext_mode (in_ext_mode),
        .in_src_sel  (in_src_sel),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_a       (out_a),
        .out_b       (out_b),
        .out_imm_ext (out_imm_ext),
        .out_err     (out_err)
    );

    imm_extender #(.DATA_W(16), .IMM_W(16)) u_e16 (
        .i_imm (e16_imm), .i_mode (e16_mode), .o_ext_c (e16_ext), .o_err_c (e16_err)
    );

    imm_extender #(.DATA_W(64), .IMM_W(16)) u_e64 (
        .i_imm (e64_imm), .i_mode (e64_mode), .o_ext_c (e64_ext), .o_err_c (e64_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Offer one set (retrying while stalled) and push its hand-computed result on accept.
    task automatic send(input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] imm,
                        input logic [1:0] mode, input logic sel,
                        input logic [31:0] eb, input logic [31:0] eimm, input logic eerr);
        int  n    = 0;
        bit  done = 0;
        in_valid    = 1'b1;
        in_rs       = rs;
        in_rt       = rt;
        in_imm      = imm;
        in_ext_mode = mode;
        in_src_sel  = sel;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back('{a: rs, b: eb, imm: eimm, err: eerr});
                done = 1;
            end else begin
                n++;
                if (n > 50) begin
                    checks++;
                    errors++;
                    $display("FAIL send_timeout: got in_ready=0 for %0d cycles expected accept", n);
                    done = 1;
                end
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    // Monitor: every consumed output is compared against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got out_a=%h expected no output", out_a);
                end else begin
                    e = sb.pop_front();
                    check("out_a", 64'(out_a), 64'(e.a));
                    check("out_b", 64'(out_b), 64'(e.b));
                    check("out_imm_ext", 64'(out_imm_ext), 64'(e.imm));
                    check("out_err", 64'(out_err), 64'(e.err));
                    n_pop++;
                end
            end
        end
    end

    initial begin
        int start_pop;
        reset = 1'b1;
        in_valid = 1'b1;
        in_rs = 32'h0000_0063;
        in_rt = '0;
        in_imm = '0;
        in_ext_mode = 2'b00;
        in_src_sel = 1'b0;
        out_ready = 1'b1;
        e16_imm = 16'h8001;
        e16_mode = 2'b00;
        e64_imm = 16'h8000;
        e64_mode = 2'b00;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_a", 64'(out_a), 64'd0);
        check("rst_out_b", 64'(out_b), 64'd0);
        check("rst_out_imm", 64'(out_imm_ext), 64'd0);
        check("rst_out_err", 64'(out_err), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("rst_offer_ignored", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;

        // Extension modes, B from immediate, then B from register.
        send(32'h1111_1111, 32'h2222_2222, 16'hf145, 2'b00, 1'b1, 32'hffff_f145, 32'hffff_f145, 1'b0);
        @(negedge clk); check("lat_sign", 64'(out_valid), 64'd1); @(posedge clk); #1;
        send(32'h1111_1112, 32'h2222_2222, 16'hf145, 2'b01, 1'b1, 32'h0000_f145, 32'h0000_f145, 1'b0);
        @(negedge clk); check("lat_zero", 64'(out_valid), 64'd1); @(posedge clk); #1;
        send(32'h1111_1113, 32'h2222_2222, 16'hf145, 2'b10, 1'b1, 32'hf145_0000, 32'hf145_0000, 1'b0);
        @(negedge clk); check("lat_upper", 64'(out_valid), 64'd1); @(posedge clk); #1;
        send(32'h1111_1114, 32'h2222_2222, 16'hf145, 2'b11, 1'b1, 32'h0000_f145, 32'h0000_f145, 1'b1);
        @(negedge clk); check("lat_illegal", 64'(out_valid), 64'd1); @(posedge clk); #1;
        send(32'h5555_aaaa, 32'h3f57_3921, 16'hf145, 2'b00, 1'b0, 32'h3f57_3921, 32'hffff_f145, 1'b0);
        @(negedge clk); check("lat_regsel", 64'(out_valid), 64'd1); @(posedge clk); #1;

        // Backpressure: two sets buffered, third waits until the stall clears.
        out_ready = 1'b0;
        send(32'd1, 32'h0000_0011, 16'h0000, 2'b01, 1'b0, 32'h0000_0011, 32'h0, 1'b0);
        send(32'd2, 32'h0000_0022, 16'h0000, 2'b01, 1'b0, 32'h0000_0022, 32'h0, 1'b0);
        fork
            send(32'd3, 32'h0000_0033, 16'h0000, 2'b01, 1'b0, 32'h0000_0033, 32'h0, 1'b0);
            begin
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check("stall_in_ready", 64'(in_ready), 64'd0);
                    check("stall_hold_a", 64'(out_a), 64'd1);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check("drain_no_gap", 64'(out_valid), 64'd1);
                end
            end
        join
        @(posedge clk);
        #1;
        repeat (2) @(posedge clk);
        #1;

        // Streaming at full rate.
        start_pop = n_pop;
        for (int i = 0; i < 8; i++) begin
            in_valid    = 1'b1;
            in_rs       = 32'h0000_0100 + 32'(i);
            in_rt       = 32'h0000_0200 + 32'(i);
            in_imm      = 16'h0000;
            in_ext_mode = 2'b01;
            in_src_sel  = 1'b0;
            @(negedge clk);
            check("stream_in_ready", 64'(in_ready), 64'd1);
            if (in_ready)
                sb.push_back('{a: 32'h0000_0100 + 32'(i), b: 32'h0000_0200 + 32'(i), imm: 32'h0, err: 1'b0});
            if (i > 0)
                check("stream_out_valid", 64'(out_valid), 64'd1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("stream_count", 64'(n_pop - start_pop), 64'd8);

        // Reset while FULL discards both entries.
        out_ready = 1'b0;
        send(32'h0000_00a1, 32'h1, 16'h0, 2'b01, 1'b0, 32'h1, 32'h0, 1'b0);
        send(32'h0000_00a2, 32'h2, 16'h0, 2'b01, 1'b0, 32'h2, 32'h0, 1'b0);
        reset = 1'b1;
        in_valid = 1'b1;
        in_rs = 32'h0000_00ee;
        sb.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_out_a", 64'(out_a), 64'd0);
        check("midrst_out_b", 64'(out_b), 64'd0);
        check("midrst_out_imm", 64'(out_imm_ext), 64'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(32'h0000_00b1, 32'h0, 16'h8000, 2'b00, 1'b1, 32'hffff_8000, 32'hffff_8000, 1'b0);
        @(negedge clk); check("postrst_latency", 64'(out_valid), 64'd1); @(posedge clk); #1;

        // Width parameterisation of the extender.
        for (int m = 0; m < 3; m++) begin
            e16_mode = 2'(m);
            #1;
            check("w16_ext", 64'(e16_ext), 64'h8001);
            check("w16_err", 64'(e16_err), 64'd0);
        end
        e16_mode = 2'b11;
        #1;
        check("w16_illegal_err", 64'(e16_err), 64'd1);
        e64_mode = 2'b00;
        #1;
        check("w64_sign", e64_ext, 64'hffff_ffff_ffff_8000);
        e64_mode = 2'b10;
        #1;
        check("w64_upper", e64_ext, 64'h8000_0000_0000_0000);

        for (int i = 0; i < 20 && sb.size() != 0; i++)
            @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
